// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Optional two's-complement mode is enabled by defining DIV_SIGNED_EN.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    // Handshake: start is sampled only in IDLE; an accepted start latches the
    // operands. done is a one-cycle pulse during which the result outputs are
    // valid; they then hold until the next completion or reset.

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dsr_r;

    logic             accept;
    logic             last;
    logic             div_zero;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             step_ok;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

`ifdef DIV_SIGNED_EN
    logic q_neg_r;
    logic r_neg_r;

    // The most-negative value maps onto its own unsigned magnitude, so
    // most-negative / -1 falls out of the same core without a special case.
    assign dividend_mag = Dividend[WIDTH-1] ? (WIDTH'(0) - Dividend) : Dividend;
    assign divisor_mag  = Divisor[WIDTH-1]  ? (WIDTH'(0) - Divisor)  : Divisor;
    assign q_final      = q_neg_r ? (WIDTH'(0) - q_next) : q_next;
    assign r_final      = r_neg_r ? (WIDTH'(0) - r_next) : r_next;
`else
    assign dividend_mag = Dividend;
    assign divisor_mag  = Divisor;
    assign q_final      = q_next;
    assign r_final      = r_next;
`endif

    assign accept   = (state == IDLE) && start;
    assign div_zero = (Divisor == '0);
    assign last     = (cnt == CW'(WIDTH - 1));

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the
    // shifted value and the top bit of the difference is the borrow.
    assign r_shift = {rem_r, quo_r[WIDTH-1]};
    assign diff    = r_shift - {1'b0, dsr_r};
    assign step_ok = ~diff[WIDTH];
    assign r_next  = step_ok ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    assign q_next  = {quo_r[WIDTH-2:0], step_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dsr_r       <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else if (accept) begin
            if (div_zero) begin
                Quotient    <= '1;
                Remainder   <= Dividend;
                div_by_zero <= 1'b1;
            end else begin
                cnt   <= '0;
                rem_r <= '0;
                quo_r <= dividend_mag;
                dsr_r <= divisor_mag;
`ifdef DIV_SIGNED_EN
                q_neg_r <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                r_neg_r <= Dividend[WIDTH-1];
`endif
            end
        end else if (state == CALC) begin
            rem_r <= r_next;
            quo_r <= q_next;
            cnt   <= cnt + CW'(1);
            if (last) begin
                Quotient    <= q_final;
                Remainder   <= r_final;
                div_by_zero <= 1'b0;
            end
        end
    end

    assign busy      = (state == CALC);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table, exhaustive sweep and
// hand-written sequences for ignored start and asynchronous reset.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .Dividend(dividend),
        .Divisor(divisor),
        .busy(busy),
        .done(done),
        .Quotient(quotient),
        .Remainder(remainder),
        .div_by_zero(div_by_zero),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference quotient/remainder computed with the simulator's own arithmetic.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
`ifdef DIV_SIGNED_EN
        int sa;
        int sb;
        int qi;
        int ri;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            qi = sa / sb;
            ri = sa % sb;
            q = qi[W-1:0];
            r = ri[W-1:0];
            z = 1'b0;
        end
`else
        if (b == '0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
`endif
    endfunction

    // One operation: drive start for one cycle, scramble operands after the
    // accepting edge, then wait (bounded) for done. lat=0 means no done seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int lat, output int busy_cycles);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom_range(0, (1 << W) - 1));
        divisor  = W'($urandom_range(0, (1 << W) - 1));
        lat = 0;
        busy_cycles = 0;
        for (int c = 1; c <= 3 * W; c++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                lat = c;
                break;
            end
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    initial begin
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        logic [W-1:0] sq;
        logic [W-1:0] sr;
        int           lat;
        int           bc;
        int           errs;
        int           done_cnt;

`ifdef DIV_SIGNED_EN
        vecs[0] = '{4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0};
        vecs[1] = '{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0};
        vecs[2] = '{4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0};
        vecs[3] = '{4'b1001, 4'b1110, 4'b0011, 4'b1111, 1'b0};
        vecs[4] = '{4'b1001, 4'b0000, 4'b1111, 4'b1001, 1'b1};
        vecs[5] = '{4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0};
        vecs[6] = '{4'b1000, 4'b0011, 4'b1110, 4'b1110, 1'b0};
        vecs[7] = '{4'b0011, 4'b0111, 4'b0000, 4'b0011, 1'b0};
        vecs[8] = '{4'b1101, 4'b0100, 4'b0000, 4'b1101, 1'b0};
        sa = 4'd7; sb = 4'd2; sq = 4'd3; sr = 4'd1;
`else
        vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0};
        vecs[1] = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1};
        vecs[2] = '{4'd9,  4'd3,  4'd3,  4'd0, 1'b0};
        vecs[3] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
        vecs[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
        vecs[5] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        vecs[6] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0};
        vecs[7] = '{4'd14, 4'd5,  4'd2,  4'd4, 1'b0};
        vecs[8] = '{4'd8,  4'd3,  4'd2,  4'd2, 1'b0};
        sa = 4'd15; sb = 4'd2; sq = 4'd7; sr = 4'd1;
`endif

        // Reset state
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        check("rst_state", 32'(dbg_state), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, q, r, z, lat, bc);
            check($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
            check($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i), 32'(z), 32'(vecs[i].z));
            check($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].z ? 1 : W + 1);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), vecs[i].z ? 0 : W);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
            check($sformatf("vec%0d_hold_q", i), 32'(quotient), 32'(vecs[i].q));
        end

        // Exhaustive sweep with nonzero divisor
        errs = 0;
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 1; j < (1 << W); j++) begin
                model(W'(i), W'(j), eq, er, ez);
                run_op(W'(i), W'(j), q, r, z, lat, bc);
                if (q !== eq || r !== er || z !== ez || lat != W + 1) errs++;
                check($sformatf("sweep_%0d_%0d_q", i, j), 32'(q), 32'(eq));
                check($sformatf("sweep_%0d_%0d_r", i, j), 32'(r), 32'(er));
            end
        end
        $display("exhaustive sweep errors: %0d", errs);

        // start during CALC is ignored, outputs hold their previous result
        model(W'(15), W'(15), eq, er, ez);
        @(negedge clk);
        dividend = sa;
        divisor  = sb;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) begin
                dividend = 4'd6;
                divisor  = 4'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c == 3) check("ignore_hold_q", 32'(quotient), 32'(eq));
            if (done) begin
                done_cnt++;
                check("ignore_quotient", 32'(quotient), 32'(sq));
                check("ignore_remainder", 32'(remainder), 32'(sr));
                check("ignore_latency", 32'(c), W + 1);
            end
        end
        check("ignore_done_count", 32'(done_cnt), 1);

        // Asynchronous reset in the middle of an operation
`ifdef DIV_SIGNED_EN
        sa = 4'd6; sb = 4'd4; sq = 4'd1; sr = 4'd2;
`else
        sa = 4'd14; sb = 4'd5; sq = 4'd2; sr = 4'd4;
`endif
        @(negedge clk);
        dividend = sa;
        divisor  = sb;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_quotient", 32'(quotient), 0);
        check("midrst_remainder", 32'(remainder), 0);
        check("midrst_dbz", 32'(div_by_zero), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("midrst_no_activity", 32'(done_cnt), 0);
        check("midrst_quotient_after", 32'(quotient), 0);
        run_op(sa, sb, q, r, z, lat, bc);
        check("post_rst_quotient", 32'(q), 32'(sq));
        check("post_rst_remainder", 32'(r), 32'(sr));
        check("post_rst_dbz", 32'(z), 0);
        check("post_rst_latency", 32'(lat), W + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
